// File: rtl/aes_pkg.sv
// aes_pkg: shared AES word type, one-hot key-schedule states, Rcon and forward S-box
package aes_pkg;

    typedef logic [31:0] aes_word_t;

    typedef enum logic [6:0] {
        S_IDLE    = 7'b0000001,
        S_PRESENT = 7'b0000010,
        S_W3      = 7'b0000100,
        S_W2      = 7'b0001000,
        S_W1      = 7'b0010000,
        S_G       = 7'b0100000,
        S_W0      = 7'b1000000
    } state_e;

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (a^254, with 0 -> 0) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] v;
        v = a;
        for (int i = 0; i < 6; i++) v = gf_mul(gf_mul(v, v), a);
        v = gf_mul(v, v);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/key_sub_rot_word.sv
// key_sub_rot_word: combinational SubWord(RotWord(x))
module key_sub_rot_word
    import aes_pkg::*;
(
    input  aes_word_t x,
    output aes_word_t y
);
    aes_word_t r;
    assign r = {x[23:0], x[31:24]};
    assign y = {sbox(r[31:24]), sbox(r[23:16]), sbox(r[15:8]), sbox(r[7:0])};
endmodule

// File: rtl/key_exp_inv_128.sv
// key_exp_inv_128: inverse AES-128 key schedule, round 10 down to 0; KEY_EXP_INV_STATE_CHECK_EN adds illegal-state detection and recovery
module key_exp_inv_128
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         key_ack,
    input  logic [127:0] key,
    output logic         key_ready,
    output logic [3:0]   key_transform,
    output logic [127:0] key_out,
    output logic         o_state_error
);
    logic [6:0]           state_q, state_d;
    aes_word_t [3:0]      w_q, w_d;
    aes_word_t            g_q, g_d, sub_rot;
    logic [3:0]           kt_q, kt_d;
    logic                 enable_reg_q;

    key_sub_rot_word u_sub_rot (.x(w_q[3]), .y(sub_rot));

    assign key_ready     = state_q == S_PRESENT;
    assign key_transform = kt_q;
    assign key_out       = w_q;

`ifdef KEY_EXP_INV_STATE_CHECK_EN
    assign o_state_error = !(state_q inside {S_IDLE, S_PRESENT, S_W3, S_W2, S_W1, S_G, S_W0});
`else
    assign o_state_error = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        g_d     = g_q;
        kt_d    = kt_q;
        case (state_q)
            S_IDLE: begin
                if (enable && !enable_reg_q) begin
                    w_d     = key;
                    kt_d    = 4'd10;
                    state_d = S_PRESENT;
                end
            end
            S_PRESENT: state_d = key_ack ? ((kt_q == 4'd0) ? S_IDLE : S_W3) : S_PRESENT;
            S_W3: begin
                w_d[3]  = w_q[3] ^ w_q[2];
                state_d = S_W2;
            end
            S_W2: begin
                w_d[2]  = w_q[2] ^ w_q[1];
                state_d = S_W1;
            end
            S_W1: begin
                w_d[1]  = w_q[1] ^ w_q[0];
                state_d = S_G;
            end
            S_G: begin
                g_d     = sub_rot;
                state_d = S_W0;
            end
            S_W0: begin
                w_d[0]  = w_q[0] ^ g_q ^ {rcon(kt_q), 24'h0};
                kt_d    = (kt_q != 4'd0) ? kt_q - 4'd1 : kt_q;
                state_d = S_PRESENT;
            end
            default: begin
                state_d = S_IDLE;
`ifdef KEY_EXP_INV_STATE_CHECK_EN
                w_d     = '0;
                g_d     = '0;
                kt_d    = '0;
`endif
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            w_q          <= '0;
            g_q          <= '0;
            kt_q         <= '0;
            enable_reg_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            w_q          <= w_d;
            g_q          <= g_d;
            kt_q         <= kt_d;
            enable_reg_q <= enable;
        end
    end
endmodule

// File: tb/tb_key_exp_inv_128.sv
// tb_key_exp_inv_128: directed FIPS-197 vectors for the inverse key schedule
module tb_key_exp_inv_128;
    import aes_pkg::*;

    logic         clk = 1'b0;
    logic         reset, enable, key_ack;
    logic [127:0] key;
    logic         key_ready;
    logic [3:0]   key_transform;
    logic [127:0] key_out;
    logic         o_state_error;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] K10 = 128'hb6630ca6e13f0cc8c9ee2589d014f9a8;
    localparam logic [127:0] K9  = 128'h575c006e28d1294119fadc21ac7766f3;
    localparam logic [127:0] K1  = 128'h2a6c760523a3393988542cb1a0fafe17;
    localparam logic [127:0] K0  = 128'h09cf4f3cabf7158828aed2a62b7e1516;

    key_exp_inv_128 dut (
        .clk(clk), .reset(reset), .enable(enable), .key_ack(key_ack), .key(key),
        .key_ready(key_ready), .key_transform(key_transform), .key_out(key_out),
        .o_state_error(o_state_error)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic start();
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!key_ready && n < 20);
        check("ready_timeout", {127'd0, key_ready}, 128'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, {127'd0, key_ready}, 128'd0);
        check({tag, "_kt"}, {124'd0, key_transform}, 128'd0);
        check({tag, "_key"}, key_out, 128'd0);
        check({tag, "_err"}, {127'd0, o_state_error}, 128'd0);
    endtask

    initial begin
        int n;
        reset = 1'b1; enable = 1'b0; key_ack = 1'b0; key = K10;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b0;
        @(negedge clk);
        check("idle_ready", {127'd0, key_ready}, 128'd0);

        start();
        check("start_ready", {127'd0, key_ready}, 128'd1);
        check("start_kt", {124'd0, key_transform}, 128'd10);
        check("start_key", key_out, K10);

        key_ack = 1'b1;
        @(negedge clk);
        key_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("lat_low", {127'd0, key_ready}, 128'd0);
            @(negedge clk);
        end
        check("r9_ready", {127'd0, key_ready}, 128'd1);
        check("r9_kt", {124'd0, key_transform}, 128'd9);
        check("r9_key", key_out, K9);

        key_ack = 1'b1;
        for (int r = 8; r >= 0; r--) begin
            wait_ready(n);
            check("b2b_spacing", n, 128'd6);
            check("b2b_kt", {124'd0, key_transform}, r);
            if (r == 1) check("r1_key", key_out, K1);
            if (r == 0) check("r0_key", key_out, K0);
        end
        repeat (3) begin
            @(negedge clk);
            check("done_ready", {127'd0, key_ready}, 128'd0);
        end
        check("done_kt", {124'd0, key_transform}, 128'd0);
        key_ack = 1'b0;

        start();
        check("rerun_kt", {124'd0, key_transform}, 128'd10);
        key_ack = 1'b1;
        @(negedge clk);
        key_ack = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        reset = 1'b0;
        @(negedge clk);
        start();
        check("restart_ready", {127'd0, key_ready}, 128'd1);
        check("restart_kt", {124'd0, key_transform}, 128'd10);
        check("restart_key", key_out, K10);

        key_ack = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("noise_low", {127'd0, key_ready}, 128'd0);
            enable  = ~enable;
            key_ack = i < 4;
            @(negedge clk);
        end
        check("noise_ready", {127'd0, key_ready}, 128'd1);
        check("noise_kt", {124'd0, key_transform}, 128'd9);
        check("noise_key", key_out, K9);
        enable = 1'b0;
        @(negedge clk);
        check("noise_hold_kt", {124'd0, key_transform}, 128'd9);

        force dut.state_q = 7'b0000011;
        #1;
`ifdef KEY_EXP_INV_STATE_CHECK_EN
        check("bad_err", {127'd0, o_state_error}, 128'd1);
`else
        check("bad_err", {127'd0, o_state_error}, 128'd0);
`endif
        check("bad_ready", {127'd0, key_ready}, 128'd0);
        release dut.state_q;
        @(negedge clk);
        check("rec_ready", {127'd0, key_ready}, 128'd0);
        check("rec_err", {127'd0, o_state_error}, 128'd0);
`ifdef KEY_EXP_INV_STATE_CHECK_EN
        check("rec_kt", {124'd0, key_transform}, 128'd0);
        check("rec_key", key_out, 128'd0);
`else
        check("rec_kt", {124'd0, key_transform}, 128'd9);
        check("rec_key", key_out, K9);
`endif
        start();
        check("post_kt", {124'd0, key_transform}, 128'd10);
        check("post_key", key_out, K10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
